// File: rtl/bitrev_sched.sv
// bitrev_sched: shares one bit-reversal accelerator between NREQ requesters.
// Round-robin grant in IDLE, then start / wait-done / read-triplet sequencing,
// OUT_WORDS result beats back to the owner, and a quiet window while the
// accelerator self-resets before the next grant.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid_i/data_i  per-requester job request and input word (slice i = requester i)
//   req_ready_o         one-hot job accept (combinational, IDLE only)
//   rsp_valid_o         one-hot result valid towards the granted requester
//   rsp_data_o/last_o   shared result word, last-word marker
//   rsp_ready_i         per-requester result accept (only the granted bit matters)
//   acc_din_o           accelerator input word, held for the whole job
//   acc_start_o         one-cycle start pulse
//   acc_read_o          read strobe, two cycles high then one low per word
//   acc_done_i          accelerator has a result available
//   acc_dout_i          accelerator result word
//   busy_o              high in every state except IDLE
//   err_o / clr_err_i   sticky timeout flag and its clear (set wins)
module bitrev_sched #(
    parameter int unsigned NREQ       = 2,
    parameter int unsigned OUT_WORDS  = 4,
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [32*NREQ-1:0]   req_data_i,
    output logic [NREQ-1:0]      req_ready_o,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_last_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [31:0]          acc_din_o,
    output logic                 acc_start_o,
    output logic                 acc_read_o,
    input  logic                 acc_done_i,
    input  logic [31:0]          acc_dout_i,
    output logic                 busy_o,
    output logic                 err_o,
    input  logic                 clr_err_i
);

    localparam int unsigned IDX_W = (NREQ > 1)       ? $clog2(NREQ)       : 1;
    localparam int unsigned TW    = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;
    localparam int unsigned RW    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned WW    = (OUT_WORDS > 1)  ? $clog2(OUT_WORDS)  : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_DONE, RD_HI1, RD_HI2, RD_LO, RESP, RST_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [IDX_W-1:0]  gnt_q, gnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic [31:0]       din_d, data_d;
    logic              err_d;
    logic              start_d, read_d, busy_d, last_d;
    logic [NREQ-1:0]   valid_d;

    logic              found;
    logic [IDX_W-1:0]  sel, cand;

    // Round-robin search: first valid requester at or above rr_q, with wrap
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDX_W'((32'(rr_q) + k) % NREQ);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        tcnt_d      = tcnt_q;
        rcnt_d      = rcnt_q;
        wcnt_d      = wcnt_q;
        din_d       = acc_din_o;
        data_d      = rsp_data_o;
        err_d       = clr_err_i ? 1'b0 : err_o;
        req_ready_o = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_o = ONE_HOT0 << sel;
                    gnt_d       = sel;
                    rr_d        = IDX_W'((32'(sel) + 32'd1) % NREQ);
                    din_d       = req_data_i[32'(sel)*32 +: 32];
                    state_d     = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (acc_done_i) begin
                    state_d = RD_HI1;
                end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                    // Timeout beats a same-cycle clear
                    err_d   = 1'b1;
                    rcnt_d  = '0;
                    wcnt_d  = '0;
                    state_d = RST_WAIT;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            RD_HI1: state_d = RD_HI2;
            RD_HI2: state_d = RD_LO;
            RD_LO: begin
                data_d  = acc_dout_i;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i[gnt_q]) begin
                    if (wcnt_q == WW'(OUT_WORDS - 1)) begin
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = RST_WAIT;
                    end else begin
                        wcnt_d  = wcnt_q + WW'(1);
                        tcnt_d  = '0;
                        state_d = WAIT_DONE;
                    end
                end
            end
            RST_WAIT: begin
                if (rcnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they register alongside it
        start_d = (state_d == START);
        read_d  = (state_d == RD_HI1) || (state_d == RD_HI2);
        busy_d  = (state_d != IDLE);
        valid_d = (state_d == RESP) ? (ONE_HOT0 << gnt_d) : '0;
        last_d  = (state_d == RESP) && (wcnt_d == WW'(OUT_WORDS - 1));
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            tcnt_q      <= '0;
            rcnt_q      <= '0;
            wcnt_q      <= '0;
            acc_din_o   <= '0;
            rsp_data_o  <= '0;
            err_o       <= 1'b0;
            acc_start_o <= 1'b0;
            acc_read_o  <= 1'b0;
            busy_o      <= 1'b0;
            rsp_valid_o <= '0;
            rsp_last_o  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            tcnt_q      <= tcnt_d;
            rcnt_q      <= rcnt_d;
            wcnt_q      <= wcnt_d;
            acc_din_o   <= din_d;
            rsp_data_o  <= data_d;
            err_o       <= err_d;
            acc_start_o <= start_d;
            acc_read_o  <= read_d;
            busy_o      <= busy_d;
            rsp_valid_o <= valid_d;
            rsp_last_o  <= last_d;
        end
    end

endmodule

// File: doc/bitrev_sched.md
Name: bitrev_sched

Overview:
- Shares one bit-reversal accelerator between NREQ requesters (CPU bus slave, DMA) using round-robin arbitration.
- For each granted job, sequences the accelerator's start / done / read handshake.
- Returns OUT_WORDS result words to the owning requester.
- Observes the accelerator's self-reset window before the next job is granted.

Parameters:
NREQ, 2, number of requesters (1..4)
OUT_WORDS, 4, result words read per job; accelerator self-resets after this many reads
RST_CYCLES, 4, idle cycles after last read while accelerator self-resets
TIMEOUT, 1024, max cycles in WAIT_DONE before abort

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid_i  in  NREQ  job request per requester
req_data_i  in  32*NREQ  job input word, slice i = requester i
req_ready_o  out  NREQ  one-hot job accept
rsp_valid_o  out  NREQ  one-hot result valid (granted requester only)
rsp_data_o  out  32  result word (shared)
rsp_last_o  out  1  marks word OUT_WORDS-1
rsp_ready_i  in  NREQ  result accept per requester
acc_din_o  out  32  accelerator input word
acc_start_o  out  1  accelerator start pulse
acc_read_o  out  1  accelerator read strobe
acc_done_i  in  1  accelerator result available
acc_dout_i  in  32  accelerator result word
busy_o  out  1  high in every state except IDLE
err_o  out  1  sticky timeout flag
clr_err_i  in  1  clears err_o

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0; rr pointer=0; word count=0; err_o=0.
- IDLE: if any req_valid_i, grant first requester at or after the rr pointer, searching upward with wrap.
  - Same cycle: req_ready_o[g]=1 and acc_din_o<=req_data_i[g] (registered).
  - rr pointer <= g+1 mod NREQ. Next state START.
- START: acc_start_o=1 for exactly 1 cycle. acc_din_o held until the job ends. -> WAIT_DONE, timeout counter cleared.
- WAIT_DONE:
  - acc_done_i=1 -> RD_HI1.
  - Counter reaching TIMEOUT-1 -> err_o<=1, then RST_WAIT. Job dropped, no response.
- Read triplet, mandatory for every word:
  - RD_HI1: acc_read_o=1.
  - RD_HI2: acc_read_o=1.
  - RD_LO: acc_read_o=0. acc_dout_i captured into rsp_data_o on the edge leaving RD_LO. -> RESP.
  - acc_read_o is never high for 3 consecutive cycles.
- RESP:
  - rsp_valid_o[g]=1; rsp_data_o stable.
  - rsp_last_o=1 when word count==OUT_WORDS-1.
  - Holds until rsp_ready_i[g]. rsp_ready_i of non-granted requesters is ignored.
  - On accept with count<OUT_WORDS-1: count++, -> WAIT_DONE (timeout counter cleared).
  - On accept with count==OUT_WORDS-1: count=0, -> RST_WAIT.
- RST_WAIT: counts RST_CYCLES cycles with all acc_* strobes low, then IDLE.
  - Guarantees no start or read during the accelerator's self-reset.
  - Minimum job-to-job gap is therefore RST_CYCLES+1 cycles.
- Latency, done already high: first rsp_valid 5 cycles after the req_ready cycle (START, WAIT_DONE, RD_HI1, RD_HI2, RD_LO).
- req_ready_o is asserted only in IDLE. Requests arriving while busy wait, with no loss. The requester holds req_valid/data until ready.
- err_o set and clr_err_i in the same cycle: the set wins. err_o does not block new jobs.
- Reset mid-job: immediate return to IDLE, all strobes low. The accelerator is not reset by this block.

Test Plan:
- Single job: req0 data 0x0000_0001, done rises 10 cycles after start -> one start pulse; four HI,HI,LO triplets; 4 rsp beats on rsp_valid_o[0]; rsp_last_o on 4th only; 4 idle cycles before next grant.
- Contention: req0 and req1 both valid in IDLE from reset -> grant order 0,1,0,1 over four jobs; rsp_valid_o never on requester 1 during requester 0's job.
- Backpressure: rsp_ready_i[0] low 7 cycles on beat 2 -> rsp_data_o and rsp_valid_o stable; acc_read_o stays 0 during the stall; no word skipped.
- Timeout: acc_done_i held 0 -> err_o=1 exactly TIMEOUT cycles after start exit; no rsp_valid; back to IDLE after RST_CYCLES; clr_err_i pulse -> err_o=0.
- Async reset asserted in RD_HI2 -> acc_read_o=0 before the next edge; busy_o=0; rsp_valid_o=0; the following job sequences normally.
- Simultaneous clr_err_i and timeout in the same cycle -> err_o=1.
